stopwatch_timebase_counter: RTL and testbench
=============================================

Name: stopwatch_timebase_counter

Overview:
- Consumes the 100 Hz tick produced by the clock_100hz divider and turns it into stopwatch time: minutes, seconds and centiseconds, all in BCD.
- Re-times the tick into the system clk domain, detects its rising edge, and advances the count only while the run/pause FSM is in RUN.
- Sits between the divider and the display multiplexer in the stopwatch top level.

Parameters:
- SYNC_STAGES, 2, flops in the tick synchronizer chain; must be >= 2.
- MAX_MIN, 59, highest minutes value before wrap; legal range 0..59.

Ports:
- clk  input  1  system clock (100 MHz board clock).
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- tick_100hz  input  1  100 Hz level signal from clock_100hz; treated as asynchronous.
- start_stop  input  1  one-clk pulse (already debounced) that toggles run/pause.
- clear  input  1  one-clk pulse that zeroes the time and returns to IDLE.
- min_tens  output  4  BCD 0..5.
- min_ones  output  4  BCD 0..9.
- sec_tens  output  4  BCD 0..5.
- sec_ones  output  4  BCD 0..9.
- cs_tens  output  4  BCD 0..9, tenths of a second.
- cs_ones  output  4  BCD 0..9, hundredths of a second.
- running  output  1  1 when the FSM is in RUN.
- wrap  output  1  one-clk pulse when the count rolls over to 00:00.00.

Behaviour:
- Reset (reset=0, asynchronous): all digits 0, running=0, wrap=0, FSM=IDLE, synchronizer and edge-history flops cleared.
- Synchronizer and edge detect:
  - tick_100hz passes through SYNC_STAGES flops plus one history flop.
  - tick_edge = last sync stage & ~history.
  - If tick_100hz is first sampled high at clk edge k, the count updates at edge k+SYNC_STAGES.
  - Exactly one increment per tick rising edge, independent of tick duty cycle.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start_stop -> RUN.
  - RUN + start_stop -> PAUSE.
  - PAUSE + start_stop -> RUN.
  - Any state + clear -> IDLE with all digits zeroed.
  - running = (state==RUN), registered, and updates on the same edge as the transition.
- Increment:
  - Occurs on an edge where tick_edge=1 and the state sampled before that edge is RUN.
  - BCD ripple cascade: cs_ones 9->0 carries into cs_tens; cs_tens 9->0 into sec_ones; sec_ones 9->0 into sec_tens; sec_tens 5->0 into min_ones; min_ones 9->0 into min_tens.
  - Every digit updates on the same edge; there is no multi-cycle ripple.
- Wrap:
  - When the count is at MAX_MIN:59.99 and tick_edge=1 in RUN, all digits go to 0 and wrap=1 for exactly one clk.
  - The state stays RUN.
- Simultaneous events:
  - clear beats start_stop and tick_edge: result is IDLE, zeros, no increment, wrap=0.
  - start_stop and tick_edge in the same cycle: the increment uses the pre-transition state. RUN->PAUSE still counts that tick; PAUSE->RUN does not.
- tick_edge in IDLE or PAUSE is ignored, but the history flop still tracks the tick, so resuming never produces a spurious increment.
- No digit ever holds an illegal BCD code; an illegal value cannot arise because reset and clear are the only load paths.
- Reset asserted mid-count forces the reset values immediately. After release, the first increment requires a fresh rising edge on tick_100hz: a tick already high at release must not count.

Test Plan:
1. Reset and basic count: reset low for 10 clk then high; pulse start_stop; drive 15 tick rising edges -> digits read 00:00.15, running=1, each update exactly SYNC_STAGES clk after the tick is sampled high.
2. Pause and resume: after 15 ticks, pulse start_stop; drive 20 ticks -> count held at 00:00.15, running=0. Pulse start_stop; drive 5 ticks -> 00:00.20.
3. Carry chain: run for 6000 ticks with a fast bench tick (period 8 clk) -> exactly 01:00.00, with no intermediate illegal BCD code observed.
4. Wrap (MAX_MIN=0): run 6000 ticks -> digits 00:00.00, wrap high for exactly 1 clk, running stays 1. Tick 6001 -> 00:00.01.
5. Collisions:
   - clear + tick_edge same cycle at 00:00.42 -> 00:00.00, IDLE.
   - start_stop + tick_edge in RUN at 00:00.07 -> 00:00.08, PAUSE.
   - start_stop + tick_edge in PAUSE -> no increment, RUN.
6. Async reset mid-run: at 00:03.27 assert reset between clk edges -> outputs zero before the next clk edge. Release with tick_100hz held high -> no increment until tick falls and rises again.

Source files
------------

// File: rtl/stopwatch_timebase_counter.sv
// ---------------------------------------------------------------------------
// stopwatch_timebase_counter
//   Turns the asynchronous 100 Hz tick into a BCD stopwatch time
//   (MM:SS.cc). The tick is re-timed into clk, rising-edge detected, and the
//   count advances only while the run/pause FSM is in RUN.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-low reset
//   tick_100hz  100 Hz level from the divider (asynchronous to clk)
//   start_stop  one-clk pulse, toggles run/pause (IDLE starts running)
//   clear       one-clk pulse, zeroes the time and returns to IDLE
//   min_tens    BCD minutes tens
//   min_ones    BCD minutes ones
//   sec_tens    BCD seconds tens
//   sec_ones    BCD seconds ones
//   cs_tens     BCD tenths of a second
//   cs_ones     BCD hundredths of a second
//   running     1 while the FSM is in RUN
//   wrap        one-clk pulse when the count rolls over to 00:00.00
// ---------------------------------------------------------------------------
module stopwatch_timebase_counter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_MIN     = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_100hz,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] cs_ones,
  output logic       running,
  output logic       wrap
);

  localparam int unsigned DW = 4;
  localparam int unsigned SW = 2;

  localparam logic [DW-1:0] MAX_MIN_TENS = DW'(MAX_MIN / 10);
  localparam logic [DW-1:0] MAX_MIN_ONES = DW'(MAX_MIN % 10);
  localparam logic [DW-1:0] BCD_NINE     = DW'(9);
  localparam logic [DW-1:0] BCD_FIVE     = DW'(5);
  localparam logic [DW-1:0] BCD_ZERO     = DW'(0);
  localparam logic [DW-1:0] BCD_ONE      = DW'(1);

  localparam logic [SW-1:0] ST_IDLE  = 2'd0;
  localparam logic [SW-1:0] ST_RUN   = 2'd1;
  localparam logic [SW-1:0] ST_PAUSE = 2'd2;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_tick_hist;
  logic                   w_tick_edge;

  logic [SW-1:0] r_state;
  logic [SW-1:0] w_state_nxt;
  logic          r_running;

  logic [DW-1:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones, r_cs_tens, r_cs_ones;
  logic [DW-1:0] w_min_tens, w_min_ones, w_sec_tens, w_sec_ones, w_cs_tens, w_cs_ones;
  logic          r_wrap;
  logic          w_wrap_nxt;

  logic w_inc;
  logic w_at_max;
  logic w_c0, w_c1, w_c2, w_c3, w_c4;

  // Tick synchronizer plus one history flop for rising-edge detection.
  // The history flop follows the tick in every state, so a tick edge seen
  // while paused is consumed and never replays on resume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync      <= '0;
      r_tick_hist <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], tick_100hz};
      r_tick_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_tick_edge = r_sync[SYNC_STAGES-1] & ~r_tick_hist;

  // FSM state register; running is registered from the next state so it
  // changes on the same edge as the transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == ST_RUN);
    end
  end

  // FSM next state; clear has priority over start_stop.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else if (start_stop) begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_PAUSE;
        ST_PAUSE: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Increment qualifies on the pre-transition state, so a RUN->PAUSE toggle
  // still counts a coincident tick and PAUSE->RUN does not.
  assign w_inc = w_tick_edge && (r_state == ST_RUN) && !clear;

  assign w_at_max = (r_min_tens == MAX_MIN_TENS) && (r_min_ones == MAX_MIN_ONES) &&
                    (r_sec_tens == BCD_FIVE)     && (r_sec_ones == BCD_NINE)     &&
                    (r_cs_tens  == BCD_NINE)     && (r_cs_ones  == BCD_NINE);

  // Carry terms for the single-cycle BCD cascade.
  assign w_c0 = (r_cs_ones  == BCD_NINE);
  assign w_c1 = w_c0 && (r_cs_tens  == BCD_NINE);
  assign w_c2 = w_c1 && (r_sec_ones == BCD_NINE);
  assign w_c3 = w_c2 && (r_sec_tens == BCD_FIVE);
  assign w_c4 = w_c3 && (r_min_ones == BCD_NINE);

  // Next digit values: clear, terminal-count wrap, or ripple increment.
  always_comb begin
    w_min_tens = r_min_tens;
    w_min_ones = r_min_ones;
    w_sec_tens = r_sec_tens;
    w_sec_ones = r_sec_ones;
    w_cs_tens  = r_cs_tens;
    w_cs_ones  = r_cs_ones;
    w_wrap_nxt = 1'b0;
    if (clear || (w_inc && w_at_max)) begin
      w_min_tens = BCD_ZERO;
      w_min_ones = BCD_ZERO;
      w_sec_tens = BCD_ZERO;
      w_sec_ones = BCD_ZERO;
      w_cs_tens  = BCD_ZERO;
      w_cs_ones  = BCD_ZERO;
      w_wrap_nxt = !clear;
    end else if (w_inc) begin
      w_cs_ones = w_c0 ? BCD_ZERO : r_cs_ones + BCD_ONE;
      if (w_c0) begin
        w_cs_tens = w_c1 ? BCD_ZERO : r_cs_tens + BCD_ONE;
      end
      if (w_c1) begin
        w_sec_ones = w_c2 ? BCD_ZERO : r_sec_ones + BCD_ONE;
      end
      if (w_c2) begin
        w_sec_tens = w_c3 ? BCD_ZERO : r_sec_tens + BCD_ONE;
      end
      if (w_c3) begin
        w_min_ones = w_c4 ? BCD_ZERO : r_min_ones + BCD_ONE;
      end
      if (w_c4) begin
        w_min_tens = r_min_tens + BCD_ONE;
      end
    end
  end

  // Digit and wrap registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_min_tens <= BCD_ZERO;
      r_min_ones <= BCD_ZERO;
      r_sec_tens <= BCD_ZERO;
      r_sec_ones <= BCD_ZERO;
      r_cs_tens  <= BCD_ZERO;
      r_cs_ones  <= BCD_ZERO;
      r_wrap     <= 1'b0;
    end else begin
      r_min_tens <= w_min_tens;
      r_min_ones <= w_min_ones;
      r_sec_tens <= w_sec_tens;
      r_sec_ones <= w_sec_ones;
      r_cs_tens  <= w_cs_tens;
      r_cs_ones  <= w_cs_ones;
      r_wrap     <= w_wrap_nxt;
    end
  end

  assign min_tens = r_min_tens;
  assign min_ones = r_min_ones;
  assign sec_tens = r_sec_tens;
  assign sec_ones = r_sec_ones;
  assign cs_tens  = r_cs_tens;
  assign cs_ones  = r_cs_ones;
  assign running  = r_running;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_stopwatch_timebase_counter.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_timebase_counter
//   Two instances share all inputs: dut_a uses MAX_MIN=59, dut_b uses
//   MAX_MIN=0 so the rollover at 00:59.99 is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_stopwatch_timebase_counter;

  logic clk;
  logic reset;
  logic tick_100hz;
  logic start_stop;
  logic clear;

  logic [3:0] a_min_tens, a_min_ones, a_sec_tens, a_sec_ones, a_cs_tens, a_cs_ones;
  logic [3:0] b_min_tens, b_min_ones, b_sec_tens, b_sec_ones, b_cs_tens, b_cs_ones;
  logic       a_running, a_wrap, b_running, b_wrap;
  logic [23:0] a_dig, b_dig;

  int errors = 0;
  int checks = 0;
  int w0_wr  = 0;
  int w0_bad = 0;
  int w59_wr = 0;

  assign a_dig = {a_min_tens, a_min_ones, a_sec_tens, a_sec_ones, a_cs_tens, a_cs_ones};
  assign b_dig = {b_min_tens, b_min_ones, b_sec_tens, b_sec_ones, b_cs_tens, b_cs_ones};

  stopwatch_timebase_counter #(.SYNC_STAGES(2), .MAX_MIN(59)) dut_a (
    .clk(clk), .reset(reset), .tick_100hz(tick_100hz), .start_stop(start_stop), .clear(clear),
    .min_tens(a_min_tens), .min_ones(a_min_ones), .sec_tens(a_sec_tens), .sec_ones(a_sec_ones),
    .cs_tens(a_cs_tens), .cs_ones(a_cs_ones), .running(a_running), .wrap(a_wrap)
  );

  stopwatch_timebase_counter #(.SYNC_STAGES(2), .MAX_MIN(0)) dut_b (
    .clk(clk), .reset(reset), .tick_100hz(tick_100hz), .start_stop(start_stop), .clear(clear),
    .min_tens(b_min_tens), .min_ones(b_min_ones), .sec_tens(b_sec_tens), .sec_ones(b_sec_ones),
    .cs_tens(b_cs_tens), .cs_ones(b_cs_ones), .running(b_running), .wrap(b_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected BCD digits after n counted ticks for a given MAX_MIN.
  function automatic logic [23:0] exp_digits(input int n, input int max_min);
    int m, mins, secs, cs;
    m    = n % ((max_min + 1) * 6000);
    mins = m / 6000;
    secs = (m / 100) % 60;
    cs   = m % 100;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  // One clock; sample 1 time unit after the edge and log wrap activity.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (b_wrap === 1'b1) begin
      w0_wr++;
      if (b_dig !== 24'h0 || b_running !== 1'b1) w0_bad++;
    end
    if (a_wrap === 1'b1) w59_wr++;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  // 8-clk tick; optional start_stop/clear land on the tick_edge cycle.
  task automatic do_tick(input logic s, input logic c);
    tick_100hz = 1'b1;
    cycles(2);
    start_stop = s;
    clear      = c;
    cyc();
    start_stop = 1'b0;
    clear      = 1'b0;
    cyc();
    tick_100hz = 1'b0;
    cycles(4);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    cyc();
    start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; tick_100hz = 1'b0; start_stop = 1'b0; clear = 1'b0;
    cycles(10);
    checks++; if (a_dig !== 24'h0) begin errors++; $display("FAIL reset_digits_a: got %h expected %h", a_dig, 24'h0); end
    checks++; if (b_dig !== 24'h0) begin errors++; $display("FAIL reset_digits_b: got %h expected %h", b_dig, 24'h0); end
    checks++; if (a_running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", a_running); end
    checks++; if (a_wrap !== 1'b0 || b_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b%b expected 00", a_wrap, b_wrap); end
    reset = 1'b1;
    cycles(2);
    checks++; if (a_dig !== 24'h0) begin errors++; $display("FAIL post_reset_digits: got %h expected %h", a_dig, 24'h0); end
  endtask

  task automatic test_basic_count();
    pulse_ss();
    checks++; if (a_running !== 1'b1) begin errors++; $display("FAIL start_running: got %b expected 1", a_running); end
    // First tick: sampled high at edge k, count must change exactly at k+2.
    tick_100hz = 1'b1;
    cyc();
    cyc();
    checks++; if (a_dig !== 24'h0) begin errors++; $display("FAIL latency_early: got %h expected %h", a_dig, 24'h0); end
    cyc();
    checks++; if (a_dig !== 24'h000001) begin errors++; $display("FAIL latency_on_time: got %h expected %h", a_dig, 24'h000001); end
    cyc();
    tick_100hz = 1'b0;
    cycles(4);
    repeat (14) do_tick(1'b0, 1'b0);
    checks++; if (a_dig !== 24'h000015) begin errors++; $display("FAIL basic_count_a: got %h expected %h", a_dig, 24'h000015); end
    checks++; if (b_dig !== 24'h000015) begin errors++; $display("FAIL basic_count_b: got %h expected %h", b_dig, 24'h000015); end
    checks++; if (a_running !== 1'b1) begin errors++; $display("FAIL basic_running: got %b expected 1", a_running); end
  endtask

  task automatic test_pause_resume();
    pulse_ss();
    checks++; if (a_running !== 1'b0) begin errors++; $display("FAIL pause_running: got %b expected 0", a_running); end
    repeat (20) do_tick(1'b0, 1'b0);
    checks++; if (a_dig !== 24'h000015) begin errors++; $display("FAIL pause_hold: got %h expected %h", a_dig, 24'h000015); end
    pulse_ss();
    checks++; if (a_running !== 1'b1) begin errors++; $display("FAIL resume_running: got %b expected 1", a_running); end
    repeat (5) do_tick(1'b0, 1'b0);
    checks++; if (a_dig !== 24'h000020) begin errors++; $display("FAIL resume_count: got %h expected %h", a_dig, 24'h000020); end
  endtask

  task automatic test_collisions();
    repeat (22) do_tick(1'b0, 1'b0);
    checks++; if (a_dig !== 24'h000042) begin errors++; $display("FAIL pre_clear_count: got %h expected %h", a_dig, 24'h000042); end
    do_tick(1'b0, 1'b1);
    checks++; if (a_dig !== 24'h0) begin errors++; $display("FAIL clear_vs_tick: got %h expected %h", a_dig, 24'h0); end
    checks++; if (a_running !== 1'b0) begin errors++; $display("FAIL clear_idle: got %b expected 0", a_running); end
    pulse_ss();
    repeat (7) do_tick(1'b0, 1'b0);
    checks++; if (a_dig !== 24'h000007) begin errors++; $display("FAIL pre_ss_count: got %h expected %h", a_dig, 24'h000007); end
    do_tick(1'b1, 1'b0);
    checks++; if (a_dig !== 24'h000008) begin errors++; $display("FAIL run_to_pause_tick: got %h expected %h", a_dig, 24'h000008); end
    checks++; if (a_running !== 1'b0) begin errors++; $display("FAIL run_to_pause_state: got %b expected 0", a_running); end
    do_tick(1'b1, 1'b0);
    checks++; if (a_dig !== 24'h000008) begin errors++; $display("FAIL pause_to_run_tick: got %h expected %h", a_dig, 24'h000008); end
    checks++; if (a_running !== 1'b1) begin errors++; $display("FAIL pause_to_run_state: got %b expected 1", a_running); end
    pulse_clr();
    checks++; if (a_dig !== 24'h0 || a_running !== 1'b0) begin errors++; $display("FAIL clear_pulse: got %h/%b expected 000000/0", a_dig, a_running); end
  endtask

  task automatic test_carry_wrap();
    int bad_a, bad_b;
    bad_a = 0; bad_b = 0;
    w0_wr = 0; w0_bad = 0; w59_wr = 0;
    pulse_ss();
    for (int n = 1; n <= 6000; n++) begin
      do_tick(1'b0, 1'b0);
      if (a_dig !== exp_digits(n, 59)) bad_a++;
      if (b_dig !== exp_digits(n, 0)) bad_b++;
    end
    checks++; if (bad_a != 0) begin errors++; $display("FAIL carry_trace_a: got %0d bad ticks expected 0", bad_a); end
    checks++; if (bad_b != 0) begin errors++; $display("FAIL carry_trace_b: got %0d bad ticks expected 0", bad_b); end
    checks++; if (a_dig !== 24'h010000) begin errors++; $display("FAIL carry_one_minute: got %h expected %h", a_dig, 24'h010000); end
    checks++; if (b_dig !== 24'h0) begin errors++; $display("FAIL wrap_zero: got %h expected %h", b_dig, 24'h0); end
    checks++; if (w0_wr != 1) begin errors++; $display("FAIL wrap_width: got %0d cycles expected 1", w0_wr); end
    checks++; if (w0_bad != 0) begin errors++; $display("FAIL wrap_context: got %0d bad cycles expected 0", w0_bad); end
    checks++; if (b_running !== 1'b1) begin errors++; $display("FAIL wrap_running: got %b expected 1", b_running); end
    checks++; if (w59_wr != 0) begin errors++; $display("FAIL no_wrap_a: got %0d cycles expected 0", w59_wr); end
    do_tick(1'b0, 1'b0);
    checks++; if (b_dig !== 24'h000001) begin errors++; $display("FAIL after_wrap_b: got %h expected %h", b_dig, 24'h000001); end
    checks++; if (a_dig !== 24'h010001) begin errors++; $display("FAIL after_wrap_a: got %h expected %h", a_dig, 24'h010001); end
  endtask

  task automatic test_async_reset();
    pulse_clr();
    pulse_ss();
    repeat (327) do_tick(1'b0, 1'b0);
    checks++; if (a_dig !== 24'h000327) begin errors++; $display("FAIL pre_reset_count: got %h expected %h", a_dig, 24'h000327); end
    // Mid-cycle assertion; outputs must clear before the next edge.
    #3;
    reset = 1'b0;
    #1;
    checks++; if (a_dig !== 24'h0 || b_dig !== 24'h0) begin errors++; $display("FAIL async_reset_digits: got %h/%h expected 000000", a_dig, b_dig); end
    checks++; if (a_running !== 1'b0) begin errors++; $display("FAIL async_reset_running: got %b expected 0", a_running); end
    tick_100hz = 1'b1;
    cycles(3);
    reset = 1'b1;
    cycles(2);
    pulse_ss();
    checks++; if (a_running !== 1'b1) begin errors++; $display("FAIL restart_running: got %b expected 1", a_running); end
    cycles(6);
    checks++; if (a_dig !== 24'h0) begin errors++; $display("FAIL high_at_release: got %h expected %h", a_dig, 24'h0); end
    tick_100hz = 1'b0;
    cycles(4);
    do_tick(1'b0, 1'b0);
    checks++; if (a_dig !== 24'h000001) begin errors++; $display("FAIL fresh_edge_count: got %h expected %h", a_dig, 24'h000001); end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_pause_resume();
    test_collisions();
    test_carry_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
